// File: rtl/ow_pkg.sv
// Shared types and constants for the 1-Wire CRC8 arbiter: FSM states, polynomial, seed.
// CRC is processed LSB-first as on the 1-Wire bus, so the polynomial is applied bit-reversed.
package ow_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] CRC_POLY     = 8'h31;
    localparam logic [7:0] CRC_INIT_DEF = 8'hFF;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        logic [7:0] poly_r;
        for (int i = 0; i < 8; i++) begin
            poly_r[i] = CRC_POLY[7-i];
        end
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ poly_r;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ow_crc_arb_if.sv
// Byte-stream bus between two requesters and the CRC arbiter, plus the result channel.
interface ow_crc_arb_if;
    logic [1:0]  s_valid;
    logic [15:0] s_data;
    logic [1:0]  s_last;
    logic [1:0]  s_abort;
    logic [1:0]  s_ready;
    logic [1:0]  r_valid;
    logic [7:0]  r_crc;
    logic [1:0]  r_err;
    logic        busy;

    modport master (
        output s_valid, s_data, s_last, s_abort,
        input  s_ready, r_valid, r_crc, r_err, busy
    );

    modport slave (
        input  s_valid, s_data, s_last, s_abort,
        output s_ready, r_valid, r_crc, r_err, busy
    );
endinterface

// File: rtl/ow_crc8_core.sv
// Single-cycle byte-wide 1-Wire CRC8 engine; init has priority over en.
module ow_crc8_core
    import ow_pkg::*;
#(
    parameter logic [7:0] CRC_INIT = CRC_INIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else if (init) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc8_byte(crc_q, data);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ow_crc_arb.sv
// Two-requester round-robin arbiter feeding one CRC8 engine; one frame at a time,
// with abort, inter-byte stall timeout and a one-cycle result pulse per frame.
module ow_crc_arb
    import ow_pkg::*;
#(
    parameter logic [7:0] CRC_INIT = CRC_INIT_DEF,
    parameter int         TMO      = 255
) (
    input  logic         clk,
    input  logic         rst,
    ow_crc_arb_if.slave  bus
);

    localparam logic [7:0] TMO_M1 = 8'(TMO - 1);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic [7:0] stall_q, stall_d;
    logic [1:0] r_valid_q, r_valid_d;
    logic [1:0] r_err_q, r_err_d;
    logic [7:0] r_crc_q;
    logic [7:0] crc;
    logic [1:0] ready;
    logic       winner, accept, core_init;
    logic       own_valid, own_last, own_abort;
    logic [7:0] own_data;

    assign own_valid = bus.s_valid[owner_q];
    assign own_last  = bus.s_last[owner_q];
    assign own_abort = bus.s_abort[owner_q];
    assign own_data  = owner_q ? bus.s_data[15:8] : bus.s_data[7:0];

    // On a tie the requester that did not own the previous frame wins.
    assign winner = (&bus.s_valid) ? ~last_owner_q : ~bus.s_valid[0];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        stall_d      = stall_q;
        r_valid_d    = '0;
        r_err_d      = '0;
        ready        = '0;
        accept       = 1'b0;
        core_init    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.s_valid) begin
                    owner_d   = winner;
                    core_init = 1'b1;
                    stall_d   = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (own_abort) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end else begin
                    ready[owner_q] = 1'b1;
                    if (own_valid) begin
                        accept  = 1'b1;
                        stall_d = '0;
                        if (own_last) begin
                            state_d            = DONE;
                            last_owner_d       = owner_q;
                            r_valid_d[owner_q] = 1'b1;
                        end
                    end else begin
                        stall_d = stall_q + 8'd1;
                        if (stall_q == TMO_M1) begin
                            state_d          = IDLE;
                            last_owner_d     = owner_q;
                            r_err_d[owner_q] = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                core_init = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            stall_q      <= '0;
            r_valid_q    <= '0;
            r_err_q      <= '0;
            r_crc_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            stall_q      <= stall_d;
            r_valid_q    <= r_valid_d;
            r_err_q      <= r_err_d;
            if (state_q == DONE) begin
                r_crc_q <= crc;
            end
        end
    end

    ow_crc8_core #(.CRC_INIT(CRC_INIT)) u_core (
        .clk  (clk),
        .rst  (rst),
        .init (core_init),
        .en   (accept),
        .data (own_data),
        .crc  (crc)
    );

    // During DONE the engine already holds the final value; afterwards the captured copy is shown.
    assign bus.r_crc   = (|r_valid_q) ? crc : r_crc_q;
    assign bus.s_ready = ready;
    assign bus.r_valid = r_valid_q;
    assign bus.r_err   = r_err_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ow_crc_arb.sv
// Directed bench for ow_crc_arb: single frame, abort, mid-frame reset, timeout,
// back-to-back arbitration and a long alternating run against a reference CRC model.
module tb_ow_crc_arb;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] last_crc;

    always #5 clk = ~clk;

    ow_crc_arb_if bus();

    ow_crc_arb #(.CRC_INIT(8'hFF), .TMO(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Classic Dallas/Maxim byte-wise CRC8 (reflected 0x31 = 0x8C).
    function automatic logic [7:0] model_crc(input logic [7:0] seed, input logic [7:0] b [8], input int n);
        logic [7:0] c;
        c = seed;
        for (int i = 0; i < n; i++) begin
            c = c ^ b[i];
            for (int j = 0; j < 8; j++) begin
                c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic idle_inputs();
        bus.s_valid = '0;
        bus.s_data  = '0;
        bus.s_last  = '0;
        bus.s_abort = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives one frame on requester req and returns the result seen in the cycle after the last byte.
    task automatic drive_frame(input int req, input int n, input logic [7:0] b [8],
                               output logic [1:0] rv, output logic [7:0] rc);
        int i;
        int cycles;
        i = 0;
        cycles = 0;
        while (i < n && cycles < 50) begin
            bus.s_valid[req]        = 1'b1;
            bus.s_data[8*req +: 8]  = b[i];
            bus.s_last[req]         = (i == n - 1);
            @(negedge clk);
            if (bus.s_ready[req]) i++;
            @(posedge clk); #1;
            cycles++;
        end
        bus.s_valid[req] = 1'b0;
        bus.s_last[req]  = 1'b0;
        @(negedge clk);
        rv = bus.r_valid;
        rc = bus.r_crc;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.s_valid = 2'b11;
        @(negedge clk);
        n_checks++; if (bus.s_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", bus.s_ready); end
        n_checks++; if (bus.r_valid !== 2'b00) begin n_fail++; $display("FAIL reset_r_valid got=%b exp=00", bus.r_valid); end
        n_checks++; if (bus.r_err !== 2'b00) begin n_fail++; $display("FAIL reset_r_err got=%b exp=00", bus.r_err); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.r_crc !== 8'h00) begin n_fail++; $display("FAIL reset_r_crc got=%h exp=00", bus.r_crc); end
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [7:0] b [8];
        logic [1:0] rdy_log [8];
        logic [1:0] rv_log [8];
        logic [7:0] crc_log [8];
        logic       busy_log [8];
        logic [7:0] exp_crc;
        int i;
        int rdy_cnt;
        int pulses;
        b = '{8'h02, 8'h1C, 8'hB8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_crc = model_crc(8'hFF, b, 3);
        i = 0;
        rdy_cnt = 0;
        pulses = 0;
        bus.s_abort[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (i < 3) begin
                bus.s_valid[0] = 1'b1; bus.s_data[7:0] = b[i]; bus.s_last[0] = (i == 2);
            end else begin
                bus.s_valid[0] = 1'b0; bus.s_last[0] = 1'b0;
            end
            @(negedge clk);
            rdy_log[c] = bus.s_ready; rv_log[c] = bus.r_valid; crc_log[c] = bus.r_crc; busy_log[c] = bus.busy;
            if (bus.s_ready == 2'b01) rdy_cnt++;
            if (bus.r_valid != 2'b00) pulses++;
            if (bus.s_ready[0] && bus.s_valid[0]) i++;
            @(posedge clk); #1;
        end
        idle_inputs();
        n_checks++; if (rdy_log[0] !== 2'b00) begin n_fail++; $display("FAIL single_idle_ready got=%b exp=00", rdy_log[0]); end
        n_checks++; if (rdy_log[1] !== 2'b01) begin n_fail++; $display("FAIL single_first_ready got=%b exp=01", rdy_log[1]); end
        n_checks++; if (rdy_cnt !== 3) begin n_fail++; $display("FAIL single_ready_cycles got=%0d exp=3", rdy_cnt); end
        n_checks++; if (rv_log[3] !== 2'b00) begin n_fail++; $display("FAIL single_early_r_valid got=%b exp=00", rv_log[3]); end
        n_checks++; if (rv_log[4] !== 2'b01) begin n_fail++; $display("FAIL single_r_valid got=%b exp=01", rv_log[4]); end
        n_checks++; if (crc_log[4] !== exp_crc) begin n_fail++; $display("FAIL single_r_crc got=%h exp=%h", crc_log[4], exp_crc); end
        n_checks++; if (busy_log[4] !== 1'b1) begin n_fail++; $display("FAIL single_done_busy got=%b exp=1", busy_log[4]); end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL single_pulse_count got=%0d exp=1", pulses); end
        n_checks++; if (crc_log[6] !== exp_crc) begin n_fail++; $display("FAIL single_crc_hold got=%h exp=%h", crc_log[6], exp_crc); end
        n_checks++; if (busy_log[6] !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got=%b exp=0", busy_log[6]); end
        last_crc = exp_crc;
    endtask

    task automatic test_abort();
        bus.s_valid[0] = 1'b1; bus.s_data[7:0] = 8'h10; bus.s_last[0] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.s_ready !== 2'b01) begin n_fail++; $display("FAIL abort_pre_ready got=%b exp=01", bus.s_ready); end
        @(posedge clk); #1;
        bus.s_data[7:0] = 8'h20; bus.s_last[0] = 1'b1; bus.s_abort[0] = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.s_ready !== 2'b00) begin n_fail++; $display("FAIL abort_ready got=%b exp=00", bus.s_ready); end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.r_valid !== 2'b00) begin n_fail++; $display("FAIL abort_r_valid got=%b exp=00", bus.r_valid); end
        n_checks++; if (bus.r_crc !== last_crc) begin n_fail++; $display("FAIL abort_crc_hold got=%h exp=%h", bus.r_crc, last_crc); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.r_valid !== 2'b00) begin n_fail++; $display("FAIL abort_late_r_valid got=%b exp=00", bus.r_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b [8];
        logic [1:0] rv;
        logic [7:0] rc;
        logic [1:0] pulses;
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        pulses = '0;
        bus.s_valid[0] = 1'b1; bus.s_data[7:0] = b[0];
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.s_data[7:0] = b[1];
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.r_crc !== 8'h00) begin n_fail++; $display("FAIL midrst_r_crc got=%h exp=00", bus.r_crc); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            pulses = pulses | bus.r_valid | bus.r_err;
            @(posedge clk); #1;
        end
        n_checks++; if (pulses !== 2'b00) begin n_fail++; $display("FAIL midrst_pulses got=%b exp=00", pulses); end
        drive_frame(0, 4, b, rv, rc);
        n_checks++; if (rv !== 2'b01) begin n_fail++; $display("FAIL midrst_resend_r_valid got=%b exp=01", rv); end
        n_checks++; if (rc !== model_crc(8'hFF, b, 4)) begin n_fail++; $display("FAIL midrst_resend_crc got=%h exp=%h", rc, model_crc(8'hFF, b, 4)); end
    endtask

    task automatic test_timeout();
        logic [7:0] b [8];
        logic [1:0] rv;
        logic [7:0] rc;
        logic [1:0] err_val;
        logic [1:0] rv_seen;
        int err_k;
        int busy_cnt;
        b = '{8'h02, 8'h1C, 8'hB8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        err_k = 0; busy_cnt = 0; err_val = '0; rv_seen = '0;
        bus.s_valid[1] = 1'b1; bus.s_data[15:8] = 8'h55; bus.s_last[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.s_ready !== 2'b10) begin n_fail++; $display("FAIL tmo_grant got=%b exp=10", bus.s_ready); end
        @(posedge clk); #1;
        bus.s_valid[1] = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            rv_seen = rv_seen | bus.r_valid;
            if (bus.busy) busy_cnt++;
            if (bus.r_err != 2'b00) begin
                err_k = k; err_val = bus.r_err;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (err_k !== 256) begin n_fail++; $display("FAIL tmo_err_cycle got=%0d exp=256", err_k); end
        n_checks++; if (err_val !== 2'b10) begin n_fail++; $display("FAIL tmo_err_bit got=%b exp=10", err_val); end
        n_checks++; if (busy_cnt !== 255) begin n_fail++; $display("FAIL tmo_busy_cycles got=%0d exp=255", busy_cnt); end
        n_checks++; if (rv_seen !== 2'b00) begin n_fail++; $display("FAIL tmo_r_valid got=%b exp=00", rv_seen); end
        drive_frame(1, 3, b, rv, rc);
        n_checks++; if (rv !== 2'b10) begin n_fail++; $display("FAIL tmo_next_r_valid got=%b exp=10", rv); end
        n_checks++; if (rc !== model_crc(8'hFF, b, 3)) begin n_fail++; $display("FAIL tmo_next_crc got=%h exp=%h", rc, model_crc(8'hFF, b, 3)); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fa [8];
        logic [7:0] fb [8];
        logic [1:0] exp_ready [10];
        logic [1:0] rdy_log [10];
        logic [1:0] rv_log [10];
        logic [7:0] crc_log [10];
        int ia;
        int ib;
        fa = '{8'hA1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        fb = '{8'h3C, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_ready = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        ia = 0; ib = 0;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.s_valid[0] = (ia < 2); bus.s_data[7:0]  = fa[ia]; bus.s_last[0] = (ia == 1);
            bus.s_valid[1] = (ib < 2); bus.s_data[15:8] = fb[ib]; bus.s_last[1] = (ib == 1);
            @(negedge clk);
            rdy_log[c] = bus.s_ready; rv_log[c] = bus.r_valid; crc_log[c] = bus.r_crc;
            if (bus.s_ready[0] && bus.s_valid[0]) ia++;
            if (bus.s_ready[1] && bus.s_valid[1]) ib++;
            @(posedge clk); #1;
        end
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (rdy_log[c] !== exp_ready[c]) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", c, rdy_log[c], exp_ready[c]); end
        end
        n_checks++; if (rv_log[3] !== 2'b01) begin n_fail++; $display("FAIL b2b_r_valid0 got=%b exp=01", rv_log[3]); end
        n_checks++; if (crc_log[3] !== model_crc(8'hFF, fa, 2)) begin n_fail++; $display("FAIL b2b_crc0 got=%h exp=%h", crc_log[3], model_crc(8'hFF, fa, 2)); end
        n_checks++; if (rv_log[7] !== 2'b10) begin n_fail++; $display("FAIL b2b_r_valid1 got=%b exp=10", rv_log[7]); end
        n_checks++; if (crc_log[7] !== model_crc(8'hFF, fb, 2)) begin n_fail++; $display("FAIL b2b_crc1 got=%h exp=%h", crc_log[7], model_crc(8'hFF, fb, 2)); end
    endtask

    task automatic test_alternating();
        logic [7:0] fr [2][8];
        logic [7:0] tmp [8];
        logic [7:0] exq0 [$];
        logic [7:0] exq1 [$];
        logic [7:0] exp_crc;
        int flen [2];
        int fidx [2];
        int fgen [2];
        int last_grant;
        int g;
        int grants;
        int done_frames;
        int cyc;
        logic [1:0] prev_ready;
        flen = '{0, 0}; fidx = '{0, 0}; fgen = '{0, 0};
        last_grant = -1; grants = 0; done_frames = 0; cyc = 0; prev_ready = '0;
        pulse_reset();
        while (done_frames < 100 && cyc < 2000) begin
            for (int k = 0; k < 2; k++) begin
                if (fidx[k] >= flen[k] && fgen[k] < 50) begin
                    flen[k] = int'($urandom_range(4, 1));
                    for (int j = 0; j < 8; j++) fr[k][j] = 8'($urandom);
                    fidx[k] = 0;
                    fgen[k]++;
                end
                if (fidx[k] < flen[k]) begin
                    bus.s_valid[k] = 1'b1; bus.s_data[8*k +: 8] = fr[k][fidx[k]]; bus.s_last[k] = (fidx[k] == flen[k] - 1);
                end else begin
                    bus.s_valid[k] = 1'b0; bus.s_last[k] = 1'b0;
                end
            end
            @(negedge clk);
            if (bus.s_ready != 2'b00 && prev_ready == 2'b00) begin
                g = bus.s_ready[1] ? 1 : 0;
                if (last_grant >= 0) begin
                    n_checks++; if (g == last_grant) begin n_fail++; $display("FAIL alt_grant frame=%0d got=%0d exp=%0d", grants, g, 1 - last_grant); end
                end
                last_grant = g;
                grants++;
            end
            prev_ready = bus.s_ready;
            if (bus.r_valid != 2'b00) begin
                if (bus.r_valid[1]) begin
                    exp_crc = (exq1.size() > 0) ? exq1.pop_front() : 8'hXX;
                end else begin
                    exp_crc = (exq0.size() > 0) ? exq0.pop_front() : 8'hXX;
                end
                n_checks++; if (bus.r_crc !== exp_crc) begin n_fail++; $display("FAIL alt_crc frame=%0d r_valid=%b got=%h exp=%h", done_frames, bus.r_valid, bus.r_crc, exp_crc); end
                done_frames++;
            end
            for (int k = 0; k < 2; k++) begin
                if (bus.s_ready[k] && bus.s_valid[k]) begin
                    if (fidx[k] == flen[k] - 1) begin
                        for (int j = 0; j < 8; j++) tmp[j] = fr[k][j];
                        if (k == 0) exq0.push_back(model_crc(8'hFF, tmp, flen[k]));
                        else        exq1.push_back(model_crc(8'hFF, tmp, flen[k]));
                    end
                    fidx[k]++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        n_checks++; if (done_frames !== 100) begin n_fail++; $display("FAIL alt_frames got=%0d exp=100", done_frames); end
        n_checks++; if (grants !== 100) begin n_fail++; $display("FAIL alt_grants got=%0d exp=100", grants); end
        n_checks++; if (exq0.size() + exq1.size() !== 0) begin n_fail++; $display("FAIL alt_leftover got=%0d exp=0", exq0.size() + exq1.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        last_crc = '0;
        test_reset();
        test_single_frame();
        test_abort();
        test_reset_midframe();
        test_timeout();
        test_back_to_back();
        test_alternating();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
